// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB stage bus: incoming retiring instruction and register-file/flag write port (WB_RETIRE_CNT_EN adds retire_cnt)
interface wb_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  // pipeline control
  logic                  stall;
  logic                  flush;

  // instruction arriving from the memory stage
  logic                  in_valid;
  logic                  in_regwrite;
  logic [REG_ADDR_W-1:0] in_dst;
  logic [1:0]            in_wb_sel;
  logic [DATA_W-1:0]     in_alu_res;
  logic [DATA_W-1:0]     in_mem_data;
  logic [DATA_W-1:0]     in_pc_plus2;
  logic                  in_z;
  logic                  in_o;
  logic                  in_n;
  logic                  in_z_en;
  logic                  in_o_en;
  logic                  in_n_en;
  logic                  in_halt;

  // register file write port and flag updates
  logic                  WriteReg;
  logic [REG_ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0]     DstData;
  logic                  Z_in;
  logic                  O_in;
  logic                  N_in;
  logic                  Z_en;
  logic                  O_en;
  logic                  N_en;
  logic                  halted;
`ifdef WB_RETIRE_CNT_EN
  logic [15:0]           retire_cnt;
`endif

  // memory-stage / testbench side
  modport master (
    output stall, flush,
    output in_valid, in_regwrite, in_dst, in_wb_sel,
    output in_alu_res, in_mem_data, in_pc_plus2,
    output in_z, in_o, in_n, in_z_en, in_o_en, in_n_en, in_halt,
`ifdef WB_RETIRE_CNT_EN
    input  retire_cnt,
`endif
    input  WriteReg, DstReg, DstData,
    input  Z_in, O_in, N_in, Z_en, O_en, N_en, halted
  );

  // writeback stage side
  modport slave (
    input  stall, flush,
    input  in_valid, in_regwrite, in_dst, in_wb_sel,
    input  in_alu_res, in_mem_data, in_pc_plus2,
    input  in_z, in_o, in_n, in_z_en, in_o_en, in_n_en, in_halt,
`ifdef WB_RETIRE_CNT_EN
    output retire_cnt,
`endif
    output WriteReg, DstReg, DstData,
    output Z_in, O_in, N_in, Z_en, O_en, N_en, halted
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, writeback select, flag enables and sticky halt (optional WB_RETIRE_CNT_EN retire counter)
module wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   wb
);

  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;

  logic                  valid_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic [1:0]            wb_sel_q;
  logic [DATA_W-1:0]     alu_res_q;
  logic [DATA_W-1:0]     mem_data_q;
  logic [DATA_W-1:0]     pc_plus2_q;
  logic                  z_q;
  logic                  o_q;
  logic                  n_q;
  logic                  z_en_q;
  logic                  o_en_q;
  logic                  n_en_q;
  logic                  halt_q;
  logic                  halted_q;

  logic                  retire_go;
  logic                  halt_retire;
  logic [DATA_W-1:0]     wb_data;

  // The captured instruction retires in a cycle where it is valid, not held
  // by a stall, and the core has not already halted.
  assign retire_go   = valid_q & ~wb.stall & ~halted_q;
  assign halt_retire = retire_go & halt_q;

  // Pipeline capture: flush inserts a bubble and beats stall; stall holds.
  // Payload fields are left untouched on flush since valid_q masks them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      dst_q      <= '0;
      wb_sel_q   <= 2'b00;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      pc_plus2_q <= '0;
      z_q        <= 1'b0;
      o_q        <= 1'b0;
      n_q        <= 1'b0;
      z_en_q     <= 1'b0;
      o_en_q     <= 1'b0;
      n_en_q     <= 1'b0;
      halt_q     <= 1'b0;
    end else if (wb.flush) begin
      valid_q    <= 1'b0;
    end else if (!wb.stall) begin
      valid_q    <= wb.in_valid;
      regwrite_q <= wb.in_regwrite;
      dst_q      <= wb.in_dst;
      wb_sel_q   <= wb.in_wb_sel;
      alu_res_q  <= wb.in_alu_res;
      mem_data_q <= wb.in_mem_data;
      pc_plus2_q <= wb.in_pc_plus2;
      z_q        <= wb.in_z;
      o_q        <= wb.in_o;
      n_q        <= wb.in_n;
      z_en_q     <= wb.in_z_en;
      o_en_q     <= wb.in_o_en;
      n_en_q     <= wb.in_n_en;
      halt_q     <= wb.in_halt;
    end
  end

  // Sticky halt: set when the HLT retires, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (halt_retire) begin
      halted_q <= 1'b1;
    end
  end

  // Writeback value select; the reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data = alu_res_q;
    case (wb_sel_q)
      SEL_MEM: wb_data = mem_data_q;
      SEL_PC:  wb_data = pc_plus2_q;
      default: wb_data = alu_res_q;
    endcase
  end

  // Register file port: R0 is hardwired zero and HLT never writes.
  assign wb.WriteReg = retire_go & regwrite_q & (dst_q != '0) & ~halt_q;
  assign wb.DstReg   = dst_q;
  assign wb.DstData  = wb_data;

  assign wb.Z_in = z_q;
  assign wb.O_in = o_q;
  assign wb.N_in = n_q;
  assign wb.Z_en = retire_go & z_en_q;
  assign wb.O_en = retire_go & o_en_q;
  assign wb.N_en = retire_go & n_en_q;

  assign wb.halted = halted_q;

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;

  // Count every retiring instruction, HLT included; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 16'h0000;
    end else if (retire_go) begin
      retire_cnt_q <= retire_cnt_q + 16'h0001;
    end
  end

  assign wb.retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural writeback model
module tb_wb_stage;

  logic clk;
  logic rst_n;

  wb_stage_if #(.DATA_W(16), .REG_ADDR_W(4)) bus ();

  wb_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // One retiring instruction as the model sees it: the writeback value is
  // resolved at capture time from the select code.
  typedef struct {
    bit valid;
    bit regwrite;
    int dst;
    int data;
    bit z, o, n;
    bit zen, oen, nen;
    bit halt;
  } slot_t;

  slot_t m;
  bit    m_halted;
  int    m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m        = '{default: 0};
    m_halted = 0;
    m_cnt    = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit retiring;
    int sel_val;
    retiring = m.valid && !bus.stall && !m_halted;
    if (retiring) m_cnt = (m_cnt + 1) % 65536;
    if (retiring && m.halt) m_halted = 1;
    if (bus.flush) begin
      m.valid = 0;
    end else if (!bus.stall) begin
      if (bus.in_wb_sel == 2'd1)      sel_val = int'(bus.in_mem_data);
      else if (bus.in_wb_sel == 2'd2) sel_val = int'(bus.in_pc_plus2);
      else                            sel_val = int'(bus.in_alu_res);
      m.valid    = bus.in_valid;
      m.regwrite = bus.in_regwrite;
      m.dst      = int'(bus.in_dst);
      m.data     = sel_val;
      m.z = bus.in_z; m.o = bus.in_o; m.n = bus.in_n;
      m.zen = bus.in_z_en; m.oen = bus.in_o_en; m.nen = bus.in_n_en;
      m.halt     = bus.in_halt;
    end
  endtask

  task automatic model_compare();
    bit live;
    bit exp_we;
    live   = m.valid && !m_halted && !bus.stall;
    exp_we = live && m.regwrite && (m.dst != 0) && !m.halt;
    check("WriteReg", 32'(bus.WriteReg), 32'(exp_we));
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("Z_en", 32'(bus.Z_en), 32'(live && m.zen));
    check("O_en", 32'(bus.O_en), 32'(live && m.oen));
    check("N_en", 32'(bus.N_en), 32'(live && m.nen));
    if (m.valid) check("DstReg", 32'(bus.DstReg), 32'(m.dst));
    if (exp_we) check("DstData", 32'(bus.DstData), 32'(m.data));
    if (live && m.zen) check("Z_in", 32'(bus.Z_in), 32'(m.z));
    if (live && m.oen) check("O_in", 32'(bus.O_in), 32'(m.o));
    if (live && m.nen) check("N_in", 32'(bus.N_in), 32'(m.n));
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", 32'(bus.retire_cnt), 32'(m_cnt));
`endif
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    #1;
    model_compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.in_valid = 0; bus.in_regwrite = 0; bus.in_dst = '0; bus.in_wb_sel = 2'b00;
    bus.in_alu_res = '0; bus.in_mem_data = '0; bus.in_pc_plus2 = '0;
    bus.in_z = 0; bus.in_o = 0; bus.in_n = 0;
    bus.in_z_en = 0; bus.in_o_en = 0; bus.in_n_en = 0; bus.in_halt = 0;
  endtask

  task automatic set_write(input logic [3:0] dst, input logic [1:0] sel,
                           input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc);
    idle_inputs();
    bus.in_valid = 1; bus.in_regwrite = 1; bus.in_dst = dst; bus.in_wb_sel = sel;
    bus.in_alu_res = alu; bus.in_mem_data = mem; bus.in_pc_plus2 = pc;
  endtask

  // Starts and ends at a negedge.
  task automatic reset_dut();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic random_inputs();
    bus.stall       = ($urandom_range(0, 3) == 0);
    bus.flush       = ($urandom_range(0, 9) == 0);
    bus.in_valid    = ($urandom_range(0, 3) != 0);
    bus.in_regwrite = 1'($urandom);
    bus.in_dst      = 4'($urandom);
    bus.in_wb_sel   = 2'($urandom);
    bus.in_alu_res  = 16'($urandom);
    bus.in_mem_data = 16'($urandom);
    bus.in_pc_plus2 = 16'($urandom);
    bus.in_z = 1'($urandom); bus.in_o = 1'($urandom); bus.in_n = 1'($urandom);
    bus.in_z_en = 1'($urandom); bus.in_o_en = 1'($urandom); bus.in_n_en = 1'($urandom);
    bus.in_halt     = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    // Reset asserted with a valid write on the inputs, before any clock edge.
    rst_n = 0;
    model_reset();
    set_write(4'd3, 2'b00, 16'h1234, 16'h0, 16'h0);
    bus.in_z_en = 1; bus.in_o_en = 1; bus.in_n_en = 1;
    #1;
    check("rst_we", 32'(bus.WriteReg), 32'd0);
    check("rst_zen", 32'(bus.Z_en), 32'd0);
    check("rst_oen", 32'(bus.O_en), 32'd0);
    check("rst_nen", 32'(bus.N_en), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_data", 32'(bus.DstData), 32'd0);
    @(negedge clk);
    reset_dut();

    // ALU write
    set_write(4'd3, 2'b00, 16'hBEEF, 16'h1111, 16'h2222);
    cycle();
    idle_inputs();
    #1;
    check("alu_we", 32'(bus.WriteReg), 32'd1);
    check("alu_dst", 32'(bus.DstReg), 32'd3);
    check("alu_data", 32'(bus.DstData), 32'hBEEF);
    @(negedge clk);
    model_edge();

    // Load path
    set_write(4'd7, 2'b01, 16'h3333, 16'hDEAD, 16'h4444);
    cycle();
    idle_inputs();
    #1;
    check("mem_data", 32'(bus.DstData), 32'hDEAD);
    @(negedge clk);
    model_edge();

    // PCS path
    set_write(4'd15, 2'b10, 16'h5555, 16'h6666, 16'h0042);
    cycle();
    idle_inputs();
    #1;
    check("pc_data", 32'(bus.DstData), 32'h0042);
    @(negedge clk);
    model_edge();

    // Reserved select behaves as ALU
    set_write(4'd2, 2'b11, 16'hA5A5, 16'h7777, 16'h8888);
    cycle();
    idle_inputs();
    cycle();

    // R0 suppression keeps the flag update
    set_write(4'd0, 2'b00, 16'hFFFF, 16'h0, 16'h0);
    bus.in_z_en = 1; bus.in_z = 1;
    cycle();
    idle_inputs();
    #1;
    check("r0_we", 32'(bus.WriteReg), 32'd0);
    check("r0_zen", 32'(bus.Z_en), 32'd1);
    check("r0_zin", 32'(bus.Z_in), 32'd1);
    @(negedge clk);
    model_edge();

    // Three-cycle stall on a valid write: exactly one write afterwards
    set_write(4'd9, 2'b00, 16'hC0DE, 16'h0, 16'h0);
    cycle();
    set_write(4'd4, 2'b00, 16'h9999, 16'h0, 16'h0);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_we", 32'(bus.WriteReg), 32'd0);
      @(negedge clk);
      model_edge();
    end
    idle_inputs();
    #1;
    check("stall_rel_we", 32'(bus.WriteReg), 32'd1);
    check("stall_rel_dst", 32'(bus.DstReg), 32'd9);
    check("stall_rel_data", 32'(bus.DstData), 32'hC0DE);
    @(negedge clk);
    model_edge();
    #1;
    check("stall_once", 32'(bus.WriteReg), 32'd0);
    @(negedge clk);
    model_edge();

    // flush together with stall yields a bubble
    set_write(4'd6, 2'b00, 16'h0BAD, 16'h0, 16'h0);
    bus.stall = 1; bus.flush = 1;
    cycle();
    idle_inputs();
    #1;
    check("flush_we", 32'(bus.WriteReg), 32'd0);
    @(negedge clk);
    model_edge();

    // Asynchronous reset while a write is on the port
    set_write(4'd8, 2'b00, 16'h7E57, 16'h0, 16'h0);
    bus.in_z_en = 1;
    cycle();
    idle_inputs();
    bus.stall = 1;
    #1;
    bus.stall = 0;
    #1;
    check("pre_arst_we", 32'(bus.WriteReg), 32'd1);
    rst_n = 0;
    #1;
    check("arst_we", 32'(bus.WriteReg), 32'd0);
    check("arst_zen", 32'(bus.Z_en), 32'd0);
    check("arst_data", 32'(bus.DstData), 32'd0);
    model_reset();
    @(negedge clk);
    reset_dut();

    // Two retires, HLT, then a write to R5 that must never happen
    set_write(4'd1, 2'b00, 16'h0001, 16'h0, 16'h0);
    cycle();
    set_write(4'd2, 2'b00, 16'h0002, 16'h0, 16'h0);
    cycle();
    set_write(4'd3, 2'b00, 16'h0003, 16'h0, 16'h0);
    bus.in_halt = 1;
    cycle();
    set_write(4'd5, 2'b00, 16'h5555, 16'h0, 16'h0);
    #1;
    check("hlt_we", 32'(bus.WriteReg), 32'd0);
    check("hlt_not_yet", 32'(bus.halted), 32'd0);
    @(negedge clk);
    model_edge();
    for (int i = 0; i < 4; i++) begin
      set_write(4'd5, 2'b00, 16'h5555, 16'h0, 16'h0);
      bus.in_z_en = 1;
      #1;
      check("halted", 32'(bus.halted), 32'd1);
      check("r5_we", 32'(bus.WriteReg), 32'd0);
      check("halt_zen", 32'(bus.Z_en), 32'd0);
`ifdef WB_RETIRE_CNT_EN
      check("cnt_frozen", 32'(bus.retire_cnt), 32'd3);
`endif
      @(negedge clk);
      model_edge();
    end
    idle_inputs();
    reset_dut();

    // Randomized segments against the model, reset between segments
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 300; c++) begin
        random_inputs();
        cycle();
      end
      idle_inputs();
      reset_dut();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback select logic for the 16-bit, 16-entry CPU.
- Captures a retiring instruction from the memory stage and selects its writeback value (ALU result, load data or PC+2).
- Drives the register file write port (WriteReg/DstReg/DstData) and the Z/O/N flag inputs and enables.
- Owns the stall/flush bubble handling and the sticky halt flag.

Parameters:
- DATA_W, 16, datapath and register width.
- REG_ADDR_W, 4, register specifier width (16 registers; R0 reads as zero).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold WB register contents this cycle.
- flush  in  1  replace incoming instruction with a bubble.
- in_valid  in  1  memory-stage instruction valid.
- in_regwrite  in  1  instruction writes a register.
- in_dst  in  REG_ADDR_W  destination register.
- in_wb_sel  in  2  00 ALU, 01 MEM, 10 PC+2, 11 reserved (treated as ALU).
- in_alu_res  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  load data.
- in_pc_plus2  in  DATA_W  link value for PCS.
- in_z, in_o, in_n  in  1 each  flag values from EX.
- in_z_en, in_o_en, in_n_en  in  1 each  flag update enables.
- in_halt  in  1  instruction is HLT.
- WriteReg  out  1  register file write enable.
- DstReg  out  REG_ADDR_W  register file write address.
- DstData  out  DATA_W  register file write data.
- Z_in, O_in, N_in  out  1 each  flag write values.
- Z_en, O_en, N_en  out  1 each  flag write enables.
- halted  out  1  sticky halt indicator.

Behaviour:
- Reset (rst_n low, async): valid_q, halted, all captured fields = 0. WriteReg, flag enables and DstData read 0 immediately, without waiting for a clock edge.
- Capture at each posedge, in priority order:
  - flush=1: valid_q <- 0; other fields don't-care. flush wins over stall.
  - else stall=1: all fields hold.
  - else: all fields load from in_*.
- Latency: one cycle. An instruction presented at edge N drives the register file write port during cycle N..N+1. The register file commits at edge N+1.
- Outputs are combinational from captured fields:
  - DstReg = dst_q.
  - DstData = mux(wb_sel_q): alu_res_q, mem_data_q, pc_plus2_q; ALU for 11.
- WriteReg = valid_q & regwrite_q & (dst_q != 0) & ~halted & ~stall.
  - R0 writes are suppressed.
  - A stalled instruction writes only on its final, non-stalled cycle; no duplicate writes.
- Flag enables: each X_en = valid_q & x_en_q & ~halted & ~stall. X_in = captured value.
- Halt:
  - When valid_q & halt_q & ~stall, halted sets at the next edge.
  - halted stays set until reset.
  - The HLT itself performs no register write, even if regwrite_q=1.
- After halted=1, every write and flag enable is forced 0 regardless of inputs.
- Bubble: valid_q=0 forces WriteReg=0 and all X_en=0. DstData value is don't-care.
- Reset mid-stall or mid-flush: reset dominates; state returns to bubble immediately.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (16 bits).
  - retire_cnt increments by 1 at each edge where valid_q & ~stall & ~halted. The HLT instruction counts once.
  - Wraps from 0xFFFF to 0x0000.
  - Resets to 0 on rst_n low.
- When undefined: no port, no counter logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_regwrite=1 -> WriteReg=0, all X_en=0, halted=0, asynchronously with no clock edge.
- ALU write: in_dst=3, in_wb_sel=00, in_alu_res=0xBEEF, in_regwrite=1 -> next cycle WriteReg=1, DstReg=3, DstData=0xBEEF.
- Select paths:
  - Load with in_mem_data=0xDEAD, sel=01 -> DstData=0xDEAD.
  - PCS with in_pc_plus2=0x0042, sel=10 -> DstData=0x0042.
- R0 suppression: in_dst=0, in_regwrite=1, in_z_en=1, in_z=1 -> WriteReg=0 while Z_en=1, Z_in=1.
- Stall/flush:
  - Stall 3 cycles on a valid write -> WriteReg=0 for 3 cycles, then 1 for exactly one cycle, with DstData held.
  - flush=1 and stall=1 together -> next cycle WriteReg=0.
- Halt: HLT followed by a valid write to R5 -> halted=1 one cycle after HLT reaches WB; R5 write never asserts. With WB_RETIRE_CNT_EN, 2 retires then HLT -> retire_cnt=3 and frozen.
